// File: rtl/input_manager_pkg.sv
// Shared constants and types for the board button front end.
package input_manager_pkg;

    localparam int BTN_LEFT   = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_ROTATE = 3;
    localparam int BTN_DROP   = 4;
    localparam int BTN_HOLD   = 5;
    localparam int BTN_COUNT  = 6;

    localparam int FRAME_W = 6;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DAS,
        RPT_ARR
    } rpt_state_t;

    function automatic logic [FRAME_W-1:0] frame_inc(
        input logic [FRAME_W-1:0] c
    );
        return (c == '1) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/input_manager_button_debounce.sv
// One button: 2-FF synchroniser, stable-level debounce and registered press edge.
module button_debounce
    import input_manager_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          d;
    logic          d_dly;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            d     <= 1'b0;
            d_dly <= 1'b0;
            press <= 1'b0;
            cnt   <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            d_dly <= d;
            press <= d & ~d_dly;
            if (s2 == d) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                d   <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level = d;

endmodule

// File: rtl/input_manager.sv
// Button pins to game_control key pulses with DAS/ARR auto-repeat.
// INPUT_SOFT_DROP_REPEAT_EN gives btn_down its own repeat FSM.
module input_manager
    import input_manager_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int DAS_FRAMES      = 10,
    parameter int ARR_FRAMES      = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_game,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_down,
    input  logic btn_rotate,
    input  logic btn_drop,
    input  logic btn_hold,
    output logic key_left,
    output logic key_right,
    output logic key_down,
    output logic key_rotate,
    output logic key_drop,
    output logic key_hold,
    output logic key_drop_held
);

`ifdef INPUT_SOFT_DROP_REPEAT_EN
    localparam int RPT_N = 3;
`else
    localparam int RPT_N = 2;
`endif

    logic [BTN_COUNT-1:0] raw;
    logic [BTN_COUNT-1:0] lvl;
    logic [BTN_COUNT-1:0] press;
    logic [RPT_N-1:0]     rpt;
    logic                 opposed;
    logic                 unused_lvl;

    assign raw = {btn_hold, btn_drop, btn_rotate,
                  btn_down, btn_right, btn_left};

    for (genvar i = 0; i < BTN_COUNT; i++) begin : g_db
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw[i]),
            .level(lvl[i]),
            .press(press[i])
        );
    end

    // Left and right held together freeze both repeat timers.
    assign opposed = lvl[BTN_LEFT] & lvl[BTN_RIGHT];

    for (genvar r = 0; r < RPT_N; r++) begin : g_rpt
        localparam int  FIRST      = (r == BTN_DOWN) ? ARR_FRAMES : DAS_FRAMES;
        localparam bit  CAN_OPPOSE = (r != BTN_DOWN);

        rpt_state_t         state;
        rpt_state_t         state_nx;
        logic [FRAME_W-1:0] cnt;
        logic [FRAME_W-1:0] cnt_nx;
        logic [FRAME_W-1:0] frames;
        logic               due;
        logic               due_nx;
        int                 limit;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state <= RPT_IDLE;
                cnt   <= '0;
                due   <= 1'b0;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
                due   <= due_nx;
            end
        end

        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            due_nx   = 1'b0;
            frames   = frame_inc(cnt);
            limit    = (state == RPT_DAS) ? FIRST : ARR_FRAMES;
            if (!lvl[r]) begin
                state_nx = RPT_IDLE;
                cnt_nx   = '0;
            end else if (press[r]) begin
                state_nx = RPT_DAS;
                cnt_nx   = '0;
            end else if (tick_game && state != RPT_IDLE
                         && !(opposed && CAN_OPPOSE)) begin
                if (32'(frames) == limit) begin
                    due_nx   = 1'b1;
                    cnt_nx   = '0;
                    state_nx = RPT_ARR;
                end else begin
                    cnt_nx = frames;
                end
            end
        end

        assign rpt[r] = due;
    end

    assign key_left      = press[BTN_LEFT]  | rpt[BTN_LEFT];
    assign key_right     = press[BTN_RIGHT] | rpt[BTN_RIGHT];
    assign key_rotate    = press[BTN_ROTATE];
    assign key_drop      = press[BTN_DROP];
    assign key_hold      = press[BTN_HOLD];
    assign key_drop_held = lvl[BTN_DROP];

`ifdef INPUT_SOFT_DROP_REPEAT_EN
    assign key_down   = press[BTN_DOWN] | rpt[BTN_DOWN];
    assign unused_lvl = lvl[BTN_ROTATE] & lvl[BTN_HOLD];
`else
    assign key_down   = press[BTN_DOWN];
    assign unused_lvl = lvl[BTN_ROTATE] & lvl[BTN_HOLD] & lvl[BTN_DOWN];
`endif

endmodule
